alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes
//
// Stage 1 captures an operand bundle when it is accepted. Stage 2 computes
// the operation from the stage-1 bundle and holds the result and flags until
// downstream takes them. Back-pressure is complete: nothing is dropped,
// duplicated or bubbled. One operation per cycle is sustained while
// downstream is ready.
//
// Parameters
//   WIDTH      operand/result width in bits (4..32, default 8)
//
// Build option
//   ALU_PIPE_SHIFT_EN  when defined, opCodes C/D/E are SHL/SHR/ASR by one bit.
//                      When undefined they are treated as reserved opCodes.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   inValid    operand bundle valid
//   inReady    block accepts a bundle this cycle
//   opA, opB   operands
//   opCode     operation select:
//                0 ADD  1 ADC  2 SUB  3 SBC  4 INC  5 DEC  6 NEG  7 PASSB
//                8 AND  9 OR   A XOR  B NOTB C SHL  D SHR  E ASR  F reserved
//   outValid   result bundle valid
//   outReady   downstream accepts the result
//   result     operation result
//   v, c, n, z overflow, carry, negative and zero flags of the current result
//   illegalOp  current result came from an unimplemented opCode
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [3:0]       opCode,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             illegalOp
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADC   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SBC   = 4'h3;
    localparam logic [3:0] OP_INC   = 4'h4;
    localparam logic [3:0] OP_DEC   = 4'h5;
    localparam logic [3:0] OP_NEG   = 4'h6;
    localparam logic [3:0] OP_PASSB = 4'h7;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;
    localparam logic [3:0] OP_NOTB  = 4'hB;
`ifdef ALU_PIPE_SHIFT_EN
    localparam logic [3:0] OP_SHL   = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_ASR   = 4'hE;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             v;
        logic             c;
        logic             ill;
    } aluRes_t;

    // Every arithmetic op is a single adder pass a + b + cin; the callers
    // pre-invert b or force a/cin to build SUB, DEC, NEG and friends.
    function automatic aluRes_t addOp(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic             cin);
        aluRes_t    r;
        logic [WIDTH:0] sum;
        logic       carryIntoMsb;
        sum          = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        // The MSB sum bit is a^b^carryIn, so the carry into the MSB falls out
        // of the operand and sum MSBs without a second adder.
        carryIntoMsb = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];
        r.res        = sum[WIDTH-1:0];
        r.c          = sum[WIDTH];
        r.v          = carryIntoMsb ^ sum[WIDTH];
        r.ill        = 1'b0;
        return r;
    endfunction

    function automatic aluRes_t logicOp(input logic [WIDTH-1:0] res);
        aluRes_t r;
        r.res = res;
        r.v   = 1'b0;
        r.c   = 1'b0;
        r.ill = 1'b0;
        return r;
    endfunction

`ifdef ALU_PIPE_SHIFT_EN
    function automatic aluRes_t shiftOp(input logic [WIDTH-1:0] res,
                                        input logic             cout);
        aluRes_t r;
        r.res = res;
        r.v   = 1'b0;
        r.c   = cout;
        r.ill = 1'b0;
        return r;
    endfunction
`endif

    function automatic aluRes_t aluCompute(input logic [3:0]       op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             cf);
        aluRes_t r;
`ifdef ALU_PIPE_SHIFT_EN
        logic signed [WIDTH-1:0] aSigned;
        aSigned = $signed(a);
`endif
        r.res = '0;
        r.v   = 1'b0;
        r.c   = 1'b0;
        r.ill = 1'b1;
        case (op)
            OP_ADD:   r = addOp(a, b, 1'b0);
            OP_ADC:   r = addOp(a, b, cf);
            OP_SUB:   r = addOp(a, ~b, 1'b1);
            OP_SBC:   r = addOp(a, ~b, cf);
            OP_INC:   r = addOp(a, '0, 1'b1);
            OP_DEC:   r = addOp(a, '1, 1'b0);
            OP_NEG:   r = addOp('0, ~b, 1'b1);
            OP_PASSB: r = logicOp(b);
            OP_AND:   r = logicOp(a & b);
            OP_OR:    r = logicOp(a | b);
            OP_XOR:   r = logicOp(a ^ b);
            OP_NOTB:  r = logicOp(~b);
`ifdef ALU_PIPE_SHIFT_EN
            OP_SHL:   r = shiftOp({a[WIDTH-2:0], 1'b0}, a[WIDTH-1]);
            OP_SHR:   r = shiftOp({1'b0, a[WIDTH-1:1]}, a[0]);
            OP_ASR:   r = shiftOp(aSigned >>> 1, a[0]);
`endif
            // Reserved opCodes keep the all-zero, illegal defaults above
            default:  ;
        endcase
        return r;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] opA_p1;
    logic [WIDTH-1:0] opB_p1;
    logic [3:0]       opCode_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] result_p2;
    logic             carryFlag;

    logic             accept;
    logic             s2Load;
    aluRes_t          aluNext;

    assign s2Load   = vld_p1 && (!vld_p2 || outReady);
    assign inReady  = !vld_p1 || s2Load;
    assign accept   = inValid && inReady;
    assign outValid = vld_p2;
    assign result   = result_p2;

    // ---- Stage 1: operand capture on acceptance ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s2Load) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opA_p1    <= opA;
            opB_p1    <= opB;
            opCode_p1 <= opCode;
        end
    end

    // ---- Stage 2: compute and hold result/flags until transferred ----
    always_comb begin
        aluNext = aluCompute(opCode_p1, opA_p1, opB_p1, carryFlag);
    end

    // carryFlag follows the carry of each op entering stage 2; ops enter in
    // acceptance order, so ADC/SBC always see their predecessor's carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            v         <= 1'b0;
            c         <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
            illegalOp <= 1'b0;
            carryFlag <= 1'b0;
        end else if (s2Load) begin
            vld_p2    <= 1'b1;
            result_p2 <= aluNext.res;
            v         <= aluNext.v;
            c         <= aluNext.c;
            n         <= aluNext.res[WIDTH-1];
            z         <= ~|aluNext.res;
            illegalOp <= aluNext.ill;
            carryFlag <= aluNext.c;
        end else if (vld_p2 && outReady) begin
            vld_p2    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- directed testbench for alu_pipe (WIDTH = 8)
// Honors ALU_PIPE_SHIFT_EN for the expected results of opCodes C/D/E.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int WIDTH = 8;

    localparam logic [3:0] ADD = 4'h0, ADC = 4'h1, SUB = 4'h2, SBC = 4'h3;
    localparam logic [3:0] INC = 4'h4, DEC = 4'h5, NEG = 4'h6, PASSB = 4'h7;
    localparam logic [3:0] AND_ = 4'h8, OR_ = 4'h9, XOR_ = 4'hA, NOTB = 4'hB;
    localparam logic [3:0] SHL = 4'hC, SHR = 4'hD, ASR = 4'hE, RSV = 4'hF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [3:0]       opCode;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             v, c, n, z;
    logic             illegalOp;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .opA      (opA),
        .opB      (opB),
        .opCode   (opCode),
        .outValid (outValid),
        .outReady (outReady),
        .result   (result),
        .v        (v),
        .c        (c),
        .n        (n),
        .z        (z),
        .illegalOp(illegalOp)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Transfers captured as {illegalOp, v, c, n, z, result}
    logic [12:0] got[$];

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [12:0] exp;
    } vec_t;
    vec_t vecs[$];

    // Inputs change only just after a rising edge, so the values seen at the
    // falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n && outValid && outReady)
            got.push_back({illegalOp, v, c, n, z, result});
    end

    task automatic checkVal(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [12:0] mk(input logic [7:0] res, input logic vf,
                                       input logic cf, input logic nf,
                                       input logic zf, input logic ill);
        return {ill, vf, cf, nf, zf, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle and hold it until the DUT accepts it
    task automatic sendOp(input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b);
        bit done;
        done    = 1'b0;
        opCode  = op;
        opA     = a;
        opB     = b;
        inValid = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            #1;
            done = inReady;
            tick();
        end
        if (!done) checkVal("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitCount(input int cnt, input string tag);
        for (int i = 0; i < 80 && got.size() < cnt; i++) tick();
        checkVal(tag, got.size(), cnt);
    endtask

    task automatic addVec(input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [12:0] exp);
        vec_t t;
        t.op  = op;
        t.a   = a;
        t.b   = b;
        t.exp = exp;
        vecs.push_back(t);
    endtask

    task automatic runVecs(input string grp);
        got.delete();
        outReady = 1'b1;
        foreach (vecs[i]) sendOp(vecs[i].op, vecs[i].a, vecs[i].b);
        inValid = 1'b0;
        waitCount(vecs.size(), {grp, "_count"});
        for (int i = 0; i < vecs.size() && i < got.size(); i++)
            checkVal($sformatf("%s_vec%0d", grp, i), got[i], vecs[i].exp);
        vecs.delete();
        got.delete();
    endtask

    logic [7:0] bpA[5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

    initial begin
        int  idx;
        bit  rdy;

        rst_n    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        opA      = '0;
        opB      = '0;
        opCode   = '0;

        // Reset state
        repeat (3) tick();
        checkVal("rst_outValid", outValid, 0);
        checkVal("rst_result", result, 0);
        checkVal("rst_flags", {v, c, n, z}, 4'b0000);
        checkVal("rst_illegal", illegalOp, 0);
        rst_n = 1'b1;
        #1;
        checkVal("rst_inReady", inReady, 1);
        tick();

        // Overflowing ADD and its exact latency
        got.delete();
        opCode  = ADD;
        opA     = 8'h7F;
        opB     = 8'h01;
        inValid = 1'b1;
        #1;
        checkVal("lat_inReady", inReady, 1);
        tick();
        inValid = 1'b0;
        checkVal("lat_cycle1_outValid", outValid, 0);
        tick();
        checkVal("lat_cycle2_outValid", outValid, 1);
        checkVal("lat_add_7f_01", {illegalOp, v, c, n, z, result},
                 mk(8'h80, 1, 0, 1, 0, 0));
        waitCount(1, "lat_count");
        got.delete();

        // Arithmetic, carry chaining and boundaries
        addVec(ADD, 8'hFF, 8'h01, mk(8'h00, 0, 1, 0, 1, 0));
        addVec(ADC, 8'h00, 8'h00, mk(8'h01, 0, 0, 0, 0, 0));
        addVec(SUB, 8'h05, 8'h05, mk(8'h00, 0, 1, 0, 1, 0));
        addVec(SUB, 8'h03, 8'h05, mk(8'hFE, 0, 0, 1, 0, 0));
        addVec(SBC, 8'h10, 8'h01, mk(8'h0E, 0, 1, 0, 0, 0));
        addVec(SBC, 8'h10, 8'h01, mk(8'h0F, 0, 1, 0, 0, 0));
        addVec(INC, 8'h7F, 8'h00, mk(8'h80, 1, 0, 1, 0, 0));
        addVec(DEC, 8'h00, 8'h00, mk(8'hFF, 0, 0, 1, 0, 0));
        addVec(DEC, 8'h80, 8'h00, mk(8'h7F, 1, 1, 0, 0, 0));
        addVec(NEG, 8'h00, 8'h01, mk(8'hFF, 0, 0, 1, 0, 0));
        addVec(NEG, 8'h00, 8'h00, mk(8'h00, 0, 1, 0, 1, 0));
        addVec(NEG, 8'h00, 8'h80, mk(8'h80, 1, 0, 1, 0, 0));
        addVec(ADD, 8'h80, 8'h80, mk(8'h00, 1, 1, 0, 1, 0));
        runVecs("arith");

        // Logic ops clear carry; reserved op clears carry
        addVec(ADD,   8'hFF, 8'h01, mk(8'h00, 0, 1, 0, 1, 0));
        addVec(AND_,  8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0, 0));
        addVec(ADC,   8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0, 0));
        addVec(PASSB, 8'h00, 8'h5A, mk(8'h5A, 0, 0, 0, 0, 0));
        addVec(OR_,   8'hF0, 8'h0F, mk(8'hFF, 0, 0, 1, 0, 0));
        addVec(XOR_,  8'hAA, 8'hAA, mk(8'h00, 0, 0, 0, 1, 0));
        addVec(NOTB,  8'h00, 8'hFF, mk(8'h00, 0, 0, 0, 1, 0));
        addVec(NOTB,  8'h00, 8'h00, mk(8'hFF, 0, 0, 1, 0, 0));
        addVec(ADD,   8'hFF, 8'hFF, mk(8'hFE, 0, 1, 1, 0, 0));
        addVec(RSV,   8'h12, 8'h34, mk(8'h00, 0, 0, 0, 1, 1));
        addVec(ADC,   8'h00, 8'h00, mk(8'h00, 0, 0, 0, 1, 0));
        runVecs("logic");

        // Shift opCodes
`ifdef ALU_PIPE_SHIFT_EN
        addVec(ASR, 8'h81, 8'h00, mk(8'hC0, 0, 1, 1, 0, 0));
        addVec(SHL, 8'h81, 8'h00, mk(8'h02, 0, 1, 0, 0, 0));
        addVec(SHR, 8'h81, 8'h00, mk(8'h40, 0, 1, 0, 0, 0));
        addVec(ASR, 8'h7E, 8'h00, mk(8'h3F, 0, 0, 0, 0, 0));
`else
        addVec(ASR, 8'h81, 8'h00, mk(8'h00, 0, 0, 0, 1, 1));
        addVec(SHL, 8'h81, 8'h00, mk(8'h00, 0, 0, 0, 1, 1));
        addVec(SHR, 8'h81, 8'h00, mk(8'h00, 0, 0, 0, 1, 1));
        addVec(ASR, 8'h7E, 8'h00, mk(8'h00, 0, 0, 0, 1, 1));
`endif
        runVecs("shift");

        // Back-pressure: downstream stalls for 5 cycles with input offered
        got.delete();
        outReady = 1'b0;
        idx      = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            opCode  = INC;
            opA     = bpA[idx];
            opB     = 8'h00;
            inValid = 1'b1;
            #1;
            rdy = inReady;
            tick();
            if (rdy) idx++;
            if (outValid) checkVal("bp_hold_result", result, 8'h11);
        end
        checkVal("bp_accepted", idx, 2);
        checkVal("bp_inReady", inReady, 0);
        checkVal("bp_outValid", outValid, 1);
        checkVal("bp_none_out", got.size(), 0);
        outReady = 1'b1;
        while (idx < 5) begin
            sendOp(INC, bpA[idx], 8'h00);
            idx++;
        end
        inValid = 1'b0;
        waitCount(5, "bp_count");
        for (int i = 0; i < 5 && i < got.size(); i++)
            checkVal($sformatf("bp_order%0d", i), got[i],
                     mk(bpA[i] + 8'h01, 0, 0, 0, 0, 0));
        repeat (4) tick();
        checkVal("bp_no_dup", got.size(), 5);
        got.delete();

        // Reset with both stages full, carry pending
        outReady = 1'b0;
        sendOp(ADD, 8'hFF, 8'h01);
        sendOp(ADD, 8'h01, 8'h01);
        inValid = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
        #1;
        checkVal("midrst_outValid", outValid, 0);
        checkVal("midrst_inReady", inReady, 1);
        checkVal("midrst_result", {illegalOp, v, c, n, z, result}, 13'h0);
        tick();
        outReady = 1'b1;
        sendOp(ADC, 8'h01, 8'h01);
        inValid = 1'b0;
        waitCount(1, "midrst_count");
        if (got.size() > 0) checkVal("midrst_adc", got[0], mk(8'h02, 0, 0, 0, 0, 0));
        repeat (4) tick();
        checkVal("midrst_no_stale", got.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
